hpdcache_sram_wmask_1rw_ctrl: RTL and testbench

//   Sequencer and 2-port arbiter in front of one hpdcache_sram_wmask_1rw macro.

---
 rtl/hpdcache_sram_wmask_1rw_ctrl_pkg.sv | 16 +
 rtl/hpdcache_sram_wmask_1rw_ctrl_if.sv | 34 +++
 rtl/hpdcache_sram_wmask_1rw.sv | 32 +++
 rtl/hpdcache_sram_wmask_1rw_ctrl_arb.sv | 42 ++++
 rtl/hpdcache_sram_wmask_1rw_ctrl.sv | 131 +++++++++++++
 tb/tb_hpdcache_sram_wmask_1rw_ctrl.sv | 263 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/hpdcache_sram_wmask_1rw_ctrl_pkg.sv
// Purpose: shared types and constants for the single-port SRAM controller.
//   state_t   : sequencer states (START -> INIT -> RUN)
//   port_id_t : index of one of the NPORTS requesters
package hpdcache_sram_ctrl_pkg;

  localparam int NPORTS = 2;

  typedef logic [0:0] port_id_t;

  typedef enum logic [1:0] {
    START = 2'd0,
    INIT  = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/hpdcache_sram_wmask_1rw_ctrl_if.sv
// Purpose: request/response bus between the requesters and the controller.
//   req_valid/req_ready : per-port request handshake
//   req_we/addr/wdata/wmask : per-port access descriptor
//   rsp_valid/rsp_ready : per-port read response handshake
//   rsp_rdata           : read data shared by both ports
// The controller takes the slave modport, the requesters the master modport.
interface hpdcache_sram_wmask_1rw_ctrl_if
  import hpdcache_sram_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE = 6,
  parameter int DATA_SIZE = 64
);

  logic [NPORTS-1:0]                req_valid;
  logic [NPORTS-1:0]                req_ready;
  logic [NPORTS-1:0]                req_we;
  logic [NPORTS-1:0][ADDR_SIZE-1:0] req_addr;
  logic [NPORTS-1:0][DATA_SIZE-1:0] req_wdata;
  logic [NPORTS-1:0][DATA_SIZE-1:0] req_wmask;
  logic [NPORTS-1:0]                rsp_valid;
  logic [NPORTS-1:0]                rsp_ready;
  logic [DATA_SIZE-1:0]             rsp_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/hpdcache_sram_wmask_1rw.sv
// Purpose: behavioural single-port SRAM with bit write mask.
//   clk   : clock
//   cs    : chip select; rdata is refreshed on every selected cycle
//   we    : 1 = write (bits with wmask=1 take wdata), 0 = read
//   addr/wdata/wmask : access descriptor
//   rdata : word at addr, one cycle after cs
module hpdcache_sram_wmask_1rw #(
  parameter int ADDR_SIZE = 6,
  parameter int DATA_SIZE = 64,
  parameter int DEPTH     = 2**ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 cs,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [DATA_SIZE-1:0] wmask,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        r_mem[addr] <= (r_mem[addr] & ~wmask) | (wdata & wmask);
      end
      rdata <= r_mem[addr];
    end
  end

endmodule

// File: rtl/hpdcache_sram_wmask_1rw_ctrl_arb.sv
// Purpose: 2-input round-robin arbiter.
//   req_i    : request vector
//   en_i     : grants are only issued while enabled
//   gnt_o    : one-hot grant (or zero)
//   gnt_id_o : index of the granted input
// A lone requester always wins; on contention the pointer decides, and after
// any grant the pointer moves to the other input.
module hpdcache_rr_arb2
  import hpdcache_sram_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NPORTS-1:0] req_i,
  input  logic              en_i,
  output logic [NPORTS-1:0] gnt_o,
  output port_id_t          gnt_id_o
);

  port_id_t r_rr_ptr;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    if (en_i) begin
      case (req_i)
        2'b01:   begin gnt_o = 2'b01; gnt_id_o = 1'b0; end
        2'b10:   begin gnt_o = 2'b10; gnt_id_o = 1'b1; end
        2'b11:   begin gnt_o = NPORTS'(1) << r_rr_ptr; gnt_id_o = r_rr_ptr; end
        default: begin gnt_o = '0; gnt_id_o = '0; end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
    end else if (|gnt_o) begin
      r_rr_ptr <= ~gnt_id_o;
    end
  end

endmodule

// File: rtl/hpdcache_sram_wmask_1rw_ctrl.sv
// Purpose: sequencer + 2-port arbiter in front of one wmask 1RW SRAM macro.
//   clk_i/rst_ni  : clock, asynchronous active-low reset
//   init_done_o   : array zero-filled, requests accepted
//   bus (slave)   : per-port request/response handshake, shared rdata
//   sram_*_o      : macro controls, driven combinationally from the grant
//   sram_rdata_i  : macro read data (one cycle after cs)
// After reset the array is zero-filled (optional), then the RW port is shared
// round-robin. Read data is passed through unregistered, so new accesses are
// held off while a read response is outstanding and not being accepted.
module hpdcache_sram_wmask_1rw_ctrl
  import hpdcache_sram_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE   = 6,
  parameter int DATA_SIZE   = 64,
  parameter int DEPTH       = 2**ADDR_SIZE,
  parameter int INIT_ENABLE = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  output logic                           init_done_o,
  hpdcache_sram_wmask_1rw_ctrl_if.slave  bus,
  output logic                           sram_cs_o,
  output logic                           sram_we_o,
  output logic [ADDR_SIZE-1:0]           sram_addr_o,
  output logic [DATA_SIZE-1:0]           sram_wdata_o,
  output logic [DATA_SIZE-1:0]           sram_wmask_o,
  input  logic [DATA_SIZE-1:0]           sram_rdata_i
);

  state_t               r_state, w_state_nxt;
  logic [ADDR_SIZE-1:0] r_init_cnt;
  logic                 r_init_done;
  logic                 r_pending;
  port_id_t             r_pend_id;

  logic                 w_stall;
  logic                 w_arb_en;
  logic [NPORTS-1:0]    w_gnt;
  port_id_t             w_gnt_id;
  logic                 w_gnt_any;
  logic                 w_gnt_we;

  // The macro rdata changes on every cs, so an unconsumed response blocks
  // further accesses. In the accepting cycle a new grant is allowed.
  assign w_stall   = r_pending & ~bus.rsp_ready[r_pend_id];
  assign w_arb_en  = (r_state == RUN) & ~w_stall;
  assign w_gnt_any = |w_gnt;
  assign w_gnt_we  = bus.req_we[w_gnt_id];

  hpdcache_rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (bus.req_valid),
    .en_i     (w_arb_en),
    .gnt_o    (w_gnt),
    .gnt_id_o (w_gnt_id)
  );

  assign bus.req_ready = w_gnt;
  assign bus.rsp_valid = r_pending ? (NPORTS'(1) << r_pend_id) : '0;
  assign bus.rsp_rdata = sram_rdata_i;
  assign init_done_o   = r_init_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= START;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_wmask_o = '0;
    case (r_state)
      START: begin
        w_state_nxt = (INIT_ENABLE != 0) ? INIT : RUN;
      end
      INIT: begin
        sram_cs_o    = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = r_init_cnt;
        sram_wmask_o = '1;
        if (r_init_cnt == ADDR_SIZE'(DEPTH - 1)) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_gnt_any) begin
          sram_cs_o    = 1'b1;
          sram_we_o    = w_gnt_we;
          sram_addr_o  = bus.req_addr[w_gnt_id];
          sram_wdata_o = bus.req_wdata[w_gnt_id];
          sram_wmask_o = bus.req_wmask[w_gnt_id];
        end
      end
      default: begin
        w_state_nxt = START;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
      r_pending   <= 1'b0;
      r_pend_id   <= '0;
    end else begin
      if (r_state == INIT) begin
        r_init_cnt <= r_init_cnt + ADDR_SIZE'(1);
      end
      // Registered so it rises together with the first RUN cycle.
      if (w_state_nxt == RUN) begin
        r_init_done <= 1'b1;
      end
      // A grant always supersedes the response being accepted this cycle.
      if (w_gnt_any) begin
        r_pending <= ~w_gnt_we;
        r_pend_id <= w_gnt_id;
      end else if (r_pending && bus.rsp_ready[r_pend_id]) begin
        r_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hpdcache_sram_wmask_1rw_ctrl.sv
module tb_hpdcache_sram_wmask_1rw_ctrl;
  import hpdcache_sram_ctrl_pkg::*;

  localparam int AW = 6;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hpdcache_sram_wmask_1rw_ctrl_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();
  hpdcache_sram_wmask_1rw_ctrl_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus_ni ();

  logic          init_done, cs, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, wmask, rdata;
  logic          init_done_ni, cs_ni, we_ni;
  logic [AW-1:0] addr_ni;
  logic [DW-1:0] wdata_ni, wmask_ni, rdata_ni;

  hpdcache_sram_wmask_1rw_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(64), .INIT_ENABLE(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .init_done_o(init_done), .bus(bus),
    .sram_cs_o(cs), .sram_we_o(we), .sram_addr_o(addr), .sram_wdata_o(wdata),
    .sram_wmask_o(wmask), .sram_rdata_i(rdata)
  );
  hpdcache_sram_wmask_1rw #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(64)) u_sram (
    .clk(clk), .cs(cs), .we(we), .addr(addr), .wdata(wdata), .wmask(wmask), .rdata(rdata)
  );

  hpdcache_sram_wmask_1rw_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(64), .INIT_ENABLE(0)) dut_ni (
    .clk_i(clk), .rst_ni(rst_n), .init_done_o(init_done_ni), .bus(bus_ni),
    .sram_cs_o(cs_ni), .sram_we_o(we_ni), .sram_addr_o(addr_ni), .sram_wdata_o(wdata_ni),
    .sram_wmask_o(wmask_ni), .sram_rdata_i(rdata_ni)
  );
  hpdcache_sram_wmask_1rw #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(64)) u_sram_ni (
    .clk(clk), .cs(cs_ni), .we(we_ni), .addr(addr_ni), .wdata(wdata_ni), .wmask(wmask_ni),
    .rdata(rdata_ni)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p(input int p, input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] m);
    bus.req_valid[p] = v;
    bus.req_we[p]    = w;
    bus.req_addr[p]  = a;
    bus.req_wdata[p] = d;
    bus.req_wmask[p] = m;
  endtask

  logic [1:0]    exp_v;
  logic [DW-1:0] exp_d;
  int            wcnt;

  initial begin
    bus.rsp_ready       = 2'b11;
    bus_ni.req_valid    = 2'b01;
    bus_ni.req_we       = '0;
    bus_ni.req_addr     = '0;
    bus_ni.req_wdata    = '0;
    bus_ni.req_wmask    = '0;
    bus_ni.rsp_ready    = 2'b11;
    set_p(0, 1'b1, 1'b0, 6'd0, '0, '0);
    set_p(1, 1'b1, 1'b0, 6'd0, '0, '0);

    // 1: reset values, fill sequence, ready timing, zeroed array
    @(posedge clk);
    #1;
    check_val("rst_rdy", 64'(bus.req_ready), 64'd0);
    check_val("rst_rsp", 64'(bus.rsp_valid), 64'd0);
    check_val("rst_cs", 64'(cs), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 1; c <= 65; c++) begin
      @(negedge clk);
      check_val("t1_rdy", 64'(bus.req_ready), 64'd0);
      check_val("t1_done", 64'(init_done), 64'd0);
      if (c == 1) begin
        check_val("t1_start_cs", 64'(cs), 64'd0);
        check_val("t6_c1_done", 64'(init_done_ni), 64'd0);
        check_val("t6_c1_rdy", 64'(bus_ni.req_ready), 64'd0);
      end else begin
        check_val("t1_fill_cs", 64'(cs), 64'd1);
        check_val("t1_fill_we", 64'(we), 64'd1);
        check_val("t1_fill_addr", 64'(addr), 64'(c - 2));
        check_val("t1_fill_wmask", wmask, {64{1'b1}});
        check_val("t1_fill_wdata", wdata, 64'd0);
      end
      if (c == 2) begin
        check_val("t6_c2_done", 64'(init_done_ni), 64'd1);
        check_val("t6_c2_rdy", 64'(bus_ni.req_ready), 64'd1);
      end
      tick();
    end
    @(negedge clk);
    check_val("t1_done_rise", 64'(init_done), 64'd1);
    check_val("t1_first_gnt", 64'(bus.req_ready), 64'd1);
    check_val("t1_first_cs", 64'(cs), 64'd1);
    check_val("t1_first_we", 64'(we), 64'd0);
    tick();
    set_p(1, 1'b0, 1'b0, 6'd0, '0, '0);
    for (int a = 1; a < 64; a++) begin
      set_p(0, 1'b1, 1'b0, 6'(a), '0, '0);
      @(negedge clk);
      check_val("t1_rd_rdy", 64'(bus.req_ready), 64'd1);
      check_val("t1_rd_vld", 64'(bus.rsp_valid), 64'd1);
      check_val("t1_rd_zero", bus.rsp_rdata, 64'd0);
      tick();
    end
    set_p(0, 1'b0, 1'b0, 6'd0, '0, '0);
    @(negedge clk);
    check_val("t1_rd_last_vld", 64'(bus.rsp_valid), 64'd1);
    check_val("t1_rd_last", bus.rsp_rdata, 64'd0);
    tick();

    // 2: masked write then read-after-write on port 0
    set_p(0, 1'b1, 1'b1, 6'd5, {64{1'b1}}, 64'h00FF);
    @(negedge clk);
    check_val("t2_wr_rdy", 64'(bus.req_ready), 64'd1);
    check_val("t2_wr_we", 64'(we), 64'd1);
    check_val("t2_wr_addr", 64'(addr), 64'd5);
    check_val("t2_wr_mask", wmask, 64'h00FF);
    tick();
    set_p(0, 1'b1, 1'b0, 6'd5, '0, '0);
    @(negedge clk);
    check_val("t2_wr_norsp", 64'(bus.rsp_valid), 64'd0);
    check_val("t2_rd_we", 64'(we), 64'd0);
    tick();
    set_p(0, 1'b0, 1'b0, 6'd0, '0, '0);
    @(negedge clk);
    check_val("t2_rsp_vld", 64'(bus.rsp_valid), 64'd1);
    check_val("t2_rsp_data", bus.rsp_rdata, 64'h00FF);
    tick();

    // 4: port 1 response held back while port 0 waits to write
    set_p(1, 1'b1, 1'b1, 6'd3, 64'hA5, {64{1'b1}});
    @(negedge clk);
    check_val("t4_wr_rdy", 64'(bus.req_ready), 64'd2);
    tick();
    set_p(1, 1'b1, 1'b0, 6'd3, '0, '0);
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    check_val("t4_rd_rdy", 64'(bus.req_ready), 64'd2);
    tick();
    set_p(1, 1'b0, 1'b0, 6'd0, '0, '0);
    set_p(0, 1'b1, 1'b1, 6'd7, 64'h1234, {64{1'b1}});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("t4_stall_cs", 64'(cs), 64'd0);
      check_val("t4_stall_rdy", 64'(bus.req_ready), 64'd0);
      check_val("t4_stall_vld", 64'(bus.rsp_valid), 64'd2);
      check_val("t4_stall_data", bus.rsp_rdata, 64'hA5);
      tick();
    end
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    check_val("t4_acc_rdy", 64'(bus.req_ready), 64'd1);
    check_val("t4_acc_cs", 64'(cs), 64'd1);
    check_val("t4_acc_addr", 64'(addr), 64'd7);
    check_val("t4_acc_vld", 64'(bus.rsp_valid), 64'd2);
    tick();
    set_p(0, 1'b0, 1'b0, 6'd0, '0, '0);
    set_p(1, 1'b1, 1'b0, 6'd7, '0, '0);
    @(negedge clk);
    check_val("t4_pend_clr", 64'(bus.rsp_valid), 64'd0);
    check_val("t4_p1_rdy", 64'(bus.req_ready), 64'd2);
    tick();

    // 3: contention, alternating grants starting at port 0
    set_p(0, 1'b1, 1'b0, 6'd5, '0, '0);
    set_p(1, 1'b1, 1'b0, 6'd3, '0, '0);
    exp_v = 2'b10;
    exp_d = 64'h1234;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val("t3_gnt", 64'(bus.req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      check_val("t3_vld", 64'(bus.rsp_valid), 64'(exp_v));
      check_val("t3_data", bus.rsp_rdata, exp_d);
      exp_v = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (k % 2 == 0) ? 64'h00FF : 64'hA5;
      tick();
    end
    set_p(0, 1'b0, 1'b0, 6'd0, '0, '0);
    set_p(1, 1'b0, 1'b0, 6'd0, '0, '0);
    @(negedge clk);
    check_val("t3_last_vld", 64'(bus.rsp_valid), 64'(exp_v));
    check_val("t3_last_data", bus.rsp_rdata, exp_d);
    tick();

    // 5: reset in RUN with a pending response, then in INIT at init_cnt=20
    set_p(0, 1'b1, 1'b0, 6'd5, '0, '0);
    bus.rsp_ready = 2'b00;
    @(negedge clk);
    check_val("t5_rd_rdy", 64'(bus.req_ready), 64'd1);
    tick();
    set_p(0, 1'b0, 1'b0, 6'd0, '0, '0);
    #2;
    check_val("t5_pend", 64'(bus.rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("t5_async_vld", 64'(bus.rsp_valid), 64'd0);
    check_val("t5_async_done", 64'(init_done), 64'd0);
    check_val("t5_async_cs", 64'(cs), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.rsp_ready = 2'b11;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 1) check_val("t5_start_cs", 64'(cs), 64'd0);
      tick();
    end
    @(negedge clk);
    check_val("t5_cnt20_cs", 64'(cs), 64'd1);
    check_val("t5_cnt20_addr", 64'(addr), 64'd20);
    rst_n = 1'b0;
    #1;
    check_val("t5_rst2_cs", 64'(cs), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("t5_restart_start", 64'(cs), 64'd0);
    tick();
    @(negedge clk);
    check_val("t5_restart_cs", 64'(cs), 64'd1);
    check_val("t5_restart_addr", 64'(addr), 64'd0);
    wcnt = 0;
    while (!init_done && wcnt < 100) begin
      tick();
      wcnt++;
    end
    @(negedge clk);
    check_val("t5_done_timeout", 64'(init_done), 64'd1);
    check_val("t5_fill_cycles", 64'(wcnt), 64'd64);
    tick();
    set_p(0, 1'b1, 1'b0, 6'd5, '0, '0);
    @(negedge clk);
    check_val("t5_rd_rdy2", 64'(bus.req_ready), 64'd1);
    tick();
    set_p(0, 1'b0, 1'b0, 6'd0, '0, '0);
    @(negedge clk);
    check_val("t5_refill_vld", 64'(bus.rsp_valid), 64'd1);
    check_val("t5_refill_zero", bus.rsp_rdata, 64'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
